// File: rtl/mux_truth_sweeper.sv
// Self-test sequencer for a 16:1 truth-table mux: sweeps sel 0..15, captures F
// into a truth table and compares it against a mask latched at start.
module mux_truth_sweeper #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] expected,
   input  logic        mux_f,
   output logic [3:0]  sel,
   output logic        mux_e,
   output logic        busy,
   output logic        done,
   output logic [15:0] truth_table,
   output logic        match,
   output logic [4:0]  mismatch_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_index;
   logic [3:0]  w_index_nxt;
   logic [3:0]  r_settle;
   logic [3:0]  w_settle_nxt;
   logic [15:0] r_exp;
   logic [15:0] w_exp_nxt;
   logic [15:0] r_tt;
   logic [15:0] w_tt_nxt;
   logic [4:0]  r_cnt;
   logic [4:0]  w_cnt_nxt;
   logic        r_match;
   logic        w_match_nxt;
   logic [3:0]  r_sel;
   logic [3:0]  w_sel_nxt;
   logic        r_mux_e;
   logic        w_mux_e_nxt;
   logic        r_busy;
   logic        w_busy_nxt;
   logic        r_done;
   logic        w_done_nxt;
   logic        w_slot_end;
   logic        w_last;
   logic        w_bit_diff;
   logic [4:0]  w_cnt_sum;

   // One when the sampled F disagrees with the expected bit for this minterm.
   function automatic logic f_bit_differs(input logic f, input logic [15:0] mask,
                                          input logic [3:0] idx);
      return f ^ mask[idx];
   endfunction

   assign w_slot_end = (r_settle == SETTLE_LAST);
   assign w_last     = (r_index == 4'd15);
   assign w_bit_diff = f_bit_differs(mux_f, r_exp, r_index);
   assign w_cnt_sum  = r_cnt + {4'd0, w_bit_diff};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort outranks the final sample.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SWEEP;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SWEEP: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_slot_end && w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_SWEEP;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sweep datapath: index/settle counters, capture and mismatch accounting.
   always_comb begin
      w_index_nxt  = r_index;
      w_settle_nxt = r_settle;
      w_exp_nxt    = r_exp;
      w_tt_nxt     = r_tt;
      w_cnt_nxt    = r_cnt;
      w_match_nxt  = r_match;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_exp_nxt    = expected;
               w_tt_nxt     = 16'd0;
               w_cnt_nxt    = 5'd0;
               w_match_nxt  = 1'b0;
               w_index_nxt  = 4'd0;
               w_settle_nxt = 4'd0;
            end else begin
               w_exp_nxt    = r_exp;
            end
         end
         S_SWEEP: begin
            if (abort) begin
               w_match_nxt = 1'b0;
            end else if (w_slot_end) begin
               w_tt_nxt[r_index] = mux_f;
               w_cnt_nxt         = w_cnt_sum;
               w_settle_nxt      = 4'd0;
               if (w_last) begin
                  w_match_nxt = (w_cnt_sum == 5'd0);
               end else begin
                  w_index_nxt = r_index + 4'd1;
               end
            end else begin
               w_settle_nxt = r_settle + 4'd1;
            end
         end
         S_DONE:  w_match_nxt = r_match;
         default: w_match_nxt = r_match;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_index  <= 4'd0;
         r_settle <= 4'd0;
         r_exp    <= 16'd0;
         r_tt     <= 16'd0;
         r_cnt    <= 5'd0;
         r_match  <= 1'b0;
      end else begin
         r_index  <= w_index_nxt;
         r_settle <= w_settle_nxt;
         r_exp    <= w_exp_nxt;
         r_tt     <= w_tt_nxt;
         r_cnt    <= w_cnt_nxt;
         r_match  <= w_match_nxt;
      end
   end

   // Mux-facing outputs derived from the upcoming state so they register cleanly.
   always_comb begin
      w_sel_nxt   = 4'd0;
      w_mux_e_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (w_state_nxt)
         S_IDLE: begin
            w_sel_nxt   = 4'd0;
            w_mux_e_nxt = 1'b1;
         end
         S_SWEEP: begin
            w_sel_nxt   = w_index_nxt;
            w_mux_e_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
         end
         default: begin
            w_sel_nxt   = 4'd0;
            w_mux_e_nxt = 1'b1;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel   <= 4'd0;
         r_mux_e <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_sel   <= w_sel_nxt;
         r_mux_e <= w_mux_e_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign sel          = r_sel;
   assign mux_e        = r_mux_e;
   assign busy         = r_busy;
   assign done         = r_done;
   assign truth_table  = r_tt;
   assign match        = r_match;
   assign mismatch_cnt = r_cnt;

endmodule
